// File: rtl/ps2_movement_decoder_if.sv
// PS/2 pin and decoder-result bundle for ps2_movement_decoder.
// The master side drives the PS/2 lines; the slave side is the decoder.
interface ps2_movement_decoder_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [3:0] mvmt_out;
    logic [7:0] scancode_out;
    logic       scancode_valid_out;
    logic       frame_err_out;

    modport master (
        output ps2_clk_in,
        output ps2_data_in,
        input  mvmt_out,
        input  scancode_out,
        input  scancode_valid_out,
        input  frame_err_out
    );

    modport slave (
        input  ps2_clk_in,
        input  ps2_data_in,
        output mvmt_out,
        output scancode_out,
        output scancode_valid_out,
        output frame_err_out
    );
endinterface

// File: rtl/ps2_movement_decoder.sv
// PS/2 keyboard receiver that turns make/break scancodes into a held
// movement vector {forward, backward, left, right} in the pixel clock domain.
module ps2_movement_decoder #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    ps2_movement_decoder_if.slave bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_dat_sync;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic [FILTER_LEN-1:0] r_dat_hist;
    logic                  r_clk_filt;
    logic                  r_dat_filt;
    logic                  r_clk_prev;

    logic [3:0]            r_bit_cnt;
    logic [9:0]            r_frame;
    logic [TO_W-1:0]       r_to_cnt;

    logic                  r_ext;
    logic                  r_brk;
    logic [7:0]            r_held;
    logic [7:0]            r_scancode;
    logic                  r_valid;
    logic                  r_err;

    logic                  w_fall;
    logic                  w_timeout;
    logic                  w_done;
    logic                  w_ok;
    logic [7:0]            w_byte;
    logic                  w_hit;
    logic [2:0]            w_idx;
    logic                  w_ext_n;
    logic                  w_brk_n;
    logic [7:0]            w_held_n;

    // Synchronizer and glitch filter; everything presets to the idle-high level.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_hist <= '1;
            r_dat_hist <= '1;
            r_clk_filt <= 1'b1;
            r_dat_filt <= 1'b1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_data_in};
            r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            r_dat_hist <= {r_dat_hist[FILTER_LEN-2:0], r_dat_sync[1]};
            if (&r_clk_hist)
                r_clk_filt <= 1'b1;
            else if (~|r_clk_hist)
                r_clk_filt <= 1'b0;
            if (&r_dat_hist)
                r_dat_filt <= 1'b1;
            else if (~|r_dat_hist)
                r_dat_filt <= 1'b0;
            r_clk_prev <= r_clk_filt;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_filt;
    assign w_timeout = (r_to_cnt == TO_MAX);
    assign w_done    = w_fall && !w_timeout && (r_bit_cnt == 4'd10);
    assign w_byte    = r_frame[8:1];
    assign w_ok      = ~r_frame[0] & r_dat_filt & (^r_frame[9:1]);

    // Held bits [3:0] are W,S,A,D and [7:4] are up,down,left,right arrows.
    always_comb begin
        w_hit    = 1'b1;
        w_idx    = 3'd0;
        w_ext_n  = r_ext;
        w_brk_n  = r_brk;
        w_held_n = r_held;
        case ({r_ext, w_byte})
            9'h01D:  w_idx = 3'd3;
            9'h01B:  w_idx = 3'd2;
            9'h01C:  w_idx = 3'd1;
            9'h023:  w_idx = 3'd0;
            9'h175:  w_idx = 3'd7;
            9'h172:  w_idx = 3'd6;
            9'h16B:  w_idx = 3'd5;
            9'h174:  w_idx = 3'd4;
            default: w_hit = 1'b0;
        endcase
        if (w_byte == 8'hE0) begin
            w_ext_n = 1'b1;
        end else if (w_byte == 8'hF0) begin
            w_brk_n = 1'b1;
        end else if (w_byte == 8'h00 || w_byte == 8'hFF) begin
            w_held_n = '0;
            w_ext_n  = 1'b0;
            w_brk_n  = 1'b0;
        end else begin
            if (w_hit)
                w_held_n[w_idx] = ~r_brk;
            w_ext_n = 1'b0;
            w_brk_n = 1'b0;
        end
    end

    // A timeout outranks a coincident edge, which then starts a fresh frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_to_cnt   <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_held     <= '0;
            r_scancode <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_timeout) begin
                r_err    <= 1'b1;
                r_ext    <= 1'b0;
                r_brk    <= 1'b0;
                r_to_cnt <= '0;
                if (w_fall) begin
                    r_frame[0] <= r_dat_filt;
                    r_bit_cnt  <= 4'd1;
                end else begin
                    r_bit_cnt  <= '0;
                end
            end else if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_frame[r_bit_cnt] <= r_dat_filt;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (w_done) begin
                if (w_ok) begin
                    r_scancode <= w_byte;
                    r_valid    <= 1'b1;
                    r_held     <= w_held_n;
                    r_ext      <= w_ext_n;
                    r_brk      <= w_brk_n;
                end else begin
                    r_err <= 1'b1;
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign bus.mvmt_out           = r_held[7:4] | r_held[3:0];
    assign bus.scancode_out       = r_scancode;
    assign bus.scancode_valid_out = r_valid;
    assign bus.frame_err_out      = r_err;
endmodule

// File: tb/tb_ps2_movement_decoder.sv
// Self-checking bench for ps2_movement_decoder: PS/2 frames are synthesized
// bit by bit and results compared against a key-table reference model.
module tb_ps2_movement_decoder;
    localparam int unsigned TO = 400;
    localparam int unsigned H  = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_movement_decoder_if bus ();

    ps2_movement_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor
    int         n_valid = 0;
    int         n_err   = 0;
    int         n_wide  = 0;
    logic [7:0] last_sc = '0;
    logic [3:0] mv_at_valid = '0;
    logic       prev_v = 1'b0;
    logic       prev_e = 1'b0;

    always @(negedge clk) begin
        if (bus.scancode_valid_out === 1'b1) begin
            n_valid++;
            last_sc     = bus.scancode_out;
            mv_at_valid = bus.mvmt_out;
            if (prev_v) n_wide++;
        end
        if (bus.frame_err_out === 1'b1) begin
            n_err++;
            if (prev_e) n_wide++;
        end
        prev_v = (bus.scancode_valid_out === 1'b1);
        prev_e = (bus.frame_err_out === 1'b1);
    end

    // Reference model: a table of keys, each with its extended flag and code
    logic [7:0] key_code [8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    bit         key_ext  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit         m_keys   [8];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    function automatic void m_reset();
        for (int k = 0; k < 8; k++) m_keys[k] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    function automatic void m_apply(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'h00 || b == 8'hFF) m_reset();
        else begin
            for (int k = 0; k < 8; k++)
                if (key_ext[k] == m_ext && key_code[k] == b) m_keys[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [3:0] exp_mvmt();
        logic [3:0] m;
        for (int d = 0; d < 4; d++) m[3-d] = m_keys[d] | m_keys[d+4];
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_start,
                              input bit bad_stop, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ flip_par, b, bad_start};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data_in = bits[i];
            tick(10);
            if (glitch) begin
                bus.ps2_clk_in = 1'b0;
                tick(2);
                bus.ps2_clk_in = 1'b1;
            end else begin
                tick(2);
            end
            tick(H - 12);
            bus.ps2_clk_in = 1'b0;
            tick(H);
            bus.ps2_clk_in = 1'b1;
        end
        bus.ps2_data_in = 1'b1;
        tick(30);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        m_apply(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (bus.mvmt_out !== 4'b0000 || bus.scancode_out !== 8'h00 ||
            bus.scancode_valid_out !== 1'b0 || bus.frame_err_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got mvmt=%b sc=%h v=%b e=%b expected 0000/00/0/0",
                     bus.mvmt_out, bus.scancode_out, bus.scancode_valid_out, bus.frame_err_out);
        end
        tick(0);
        rst = 1'b0;
        m_reset();
        tick(20);
    endtask

    task automatic test_make();
        int v0;
        v0 = n_valid;
        send_byte(8'h1D);
        n_checks++;
        if (n_valid !== v0 + 1) begin
            n_errors++;
            $display("FAIL make_valid_count: got %0d expected %0d", n_valid - v0, 1);
        end
        n_checks++;
        if (last_sc !== 8'h1D || bus.scancode_out !== 8'h1D) begin
            n_errors++;
            $display("FAIL make_scancode: got %h/%h expected 1d", last_sc, bus.scancode_out);
        end
        n_checks++;
        if (mv_at_valid !== 4'b1000 || bus.mvmt_out !== 4'b1000) begin
            n_errors++;
            $display("FAIL make_mvmt: got %b/%b expected 1000", mv_at_valid, bus.mvmt_out);
        end
    endtask

    task automatic test_break_ext();
        int v0;
        v0 = n_valid;
        send_byte(8'hF0);
        send_byte(8'h1D);
        n_checks++;
        if (n_valid !== v0 + 2) begin
            n_errors++;
            $display("FAIL break_valid_count: got %0d expected %0d", n_valid - v0, 2);
        end
        n_checks++;
        if (mv_at_valid !== 4'b0000 || bus.mvmt_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL break_mvmt: got %b/%b expected 0000", mv_at_valid, bus.mvmt_out);
        end
        send_byte(8'hE0);
        send_byte(8'h6B);
        n_checks++;
        if (mv_at_valid !== 4'b0010 || bus.mvmt_out !== 4'b0010) begin
            n_errors++;
            $display("FAIL ext_left_mvmt: got %b/%b expected 0010", mv_at_valid, bus.mvmt_out);
        end
    endtask

    task automatic test_pair();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        n_checks++;
        if (bus.mvmt_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL ext_release_mvmt: got %b expected 0000", bus.mvmt_out);
        end
        send_byte(8'h1D); send_byte(8'hE0); send_byte(8'h75);
        n_checks++;
        if (bus.mvmt_out !== 4'b1000) begin
            n_errors++;
            $display("FAIL pair_hold_mvmt: got %b expected 1000", bus.mvmt_out);
        end
        send_byte(8'hF0); send_byte(8'h1D);
        n_checks++;
        if (mv_at_valid !== 4'b1000 || bus.mvmt_out !== 4'b1000) begin
            n_errors++;
            $display("FAIL pair_release_w_mvmt: got %b/%b expected 1000", mv_at_valid, bus.mvmt_out);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        n_checks++;
        if (mv_at_valid !== 4'b0000 || bus.mvmt_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL pair_release_up_mvmt: got %b/%b expected 0000", mv_at_valid, bus.mvmt_out);
        end
    endtask

    task automatic test_frame_err();
        int v0, e0;
        for (int k = 0; k < 3; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(8'h1C, k == 0, k == 1, k == 2, 11, 1'b0);
            m_ext = 1'b0;
            m_brk = 1'b0;
            n_checks++;
            if (n_err !== e0 + 1 || n_valid !== v0) begin
                n_errors++;
                $display("FAIL bad_frame_%0d: got err=%0d valid=%0d expected err=1 valid=0",
                         k, n_err - e0, n_valid - v0);
            end
            n_checks++;
            if (bus.mvmt_out !== 4'b0000) begin
                n_errors++;
                $display("FAIL bad_frame_mvmt_%0d: got %b expected 0000", k, bus.mvmt_out);
            end
        end
        // An error between E0 and 75 must drop the extended prefix
        send_byte(8'hE0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 11, 1'b0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_byte(8'h75);
        n_checks++;
        if (bus.mvmt_out !== exp_mvmt()) begin
            n_errors++;
            $display("FAIL err_clears_ext: got %b expected %b", bus.mvmt_out, exp_mvmt());
        end
        send_byte(8'h1C);
        n_checks++;
        if (bus.mvmt_out !== 4'b0010) begin
            n_errors++;
            $display("FAIL good_after_err_mvmt: got %b expected 0010", bus.mvmt_out);
        end
    endtask

    task automatic test_timeout();
        int v0, e0;
        send_byte(8'hFF);
        send_byte(8'hE0);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h23, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        tick(TO + 50);
        m_ext = 1'b0;
        m_brk = 1'b0;
        n_checks++;
        if (n_err !== e0 + 1 || n_valid !== v0) begin
            n_errors++;
            $display("FAIL timeout_pulse: got err=%0d valid=%0d expected err=1 valid=0",
                     n_err - e0, n_valid - v0);
        end
        send_byte(8'h23);
        n_checks++;
        if (last_sc !== 8'h23 || bus.mvmt_out !== 4'b0001) begin
            n_errors++;
            $display("FAIL after_timeout: got sc=%h mvmt=%b expected 23/0001", last_sc, bus.mvmt_out);
        end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        for (int g = 0; g < 5; g++) begin
            bus.ps2_clk_in = 1'b0;
            tick(2);
            bus.ps2_clk_in = 1'b1;
            tick(20);
        end
        send_frame(8'h1B, 1'b0, 1'b0, 1'b0, 11, 1'b1);
        m_apply(8'h1B);
        n_checks++;
        if (n_valid !== v0 + 1 || n_err !== e0) begin
            n_errors++;
            $display("FAIL glitch_counts: got valid=%0d err=%0d expected valid=1 err=0",
                     n_valid - v0, n_err - e0);
        end
        n_checks++;
        if (last_sc !== 8'h1B || bus.mvmt_out !== 4'b0101) begin
            n_errors++;
            $display("FAIL glitch_decode: got sc=%h mvmt=%b expected 1b/0101", last_sc, bus.mvmt_out);
        end
        send_byte(8'hFF);
        n_checks++;
        if (mv_at_valid !== 4'b0000 || bus.mvmt_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL overrun_clear: got %b/%b expected 0000", mv_at_valid, bus.mvmt_out);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        send_byte(8'h1D);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 6, 1'b0);
        e0 = n_err;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        n_checks++;
        if (bus.mvmt_out !== 4'b0000 || bus.scancode_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got mvmt=%b sc=%h expected 0000/00",
                     bus.mvmt_out, bus.scancode_out);
        end
        tick(TO + 50);
        n_checks++;
        if (n_err !== e0) begin
            n_errors++;
            $display("FAIL reset_mid_no_err: got %0d error pulses expected 0", n_err - e0);
        end
        send_byte(8'h23);
        n_checks++;
        if (last_sc !== 8'h23 || bus.mvmt_out !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_mid_next: got sc=%h mvmt=%b expected 23/0001", last_sc, bus.mvmt_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72,
                                  8'h6B, 8'h74, 8'hE0, 8'hE0, 8'hF0, 8'hF0};
        logic [7:0] b;
        logic [3:0] mv0;
        int v0, e0, r;
        for (int i = 0; i < 30; i++) begin
            v0 = n_valid;
            e0 = n_err;
            r  = $urandom_range(0, 15);
            if (r < 12) b = pool[$urandom_range(0, 11)];
            else if (r == 12) b = 8'hFF;
            else b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                mv0 = bus.mvmt_out;
                send_frame(b, 1'b1, 1'b0, 1'b0, 11, 1'b0);
                m_ext = 1'b0;
                m_brk = 1'b0;
                n_checks++;
                if (n_err !== e0 + 1 || n_valid !== v0 || bus.mvmt_out !== mv0) begin
                    n_errors++;
                    $display("FAIL rand_err_%0d: got err=%0d valid=%0d mvmt=%b expected 1/0/%b",
                             i, n_err - e0, n_valid - v0, bus.mvmt_out, mv0);
                end
            end else begin
                send_byte(b);
                n_checks++;
                if (n_valid !== v0 + 1 || last_sc !== b) begin
                    n_errors++;
                    $display("FAIL rand_byte_%0d: got valid=%0d sc=%h expected 1/%h",
                             i, n_valid - v0, last_sc, b);
                end
                n_checks++;
                if (mv_at_valid !== exp_mvmt() || bus.mvmt_out !== exp_mvmt()) begin
                    n_errors++;
                    $display("FAIL rand_mvmt_%0d: byte %h got %b/%b expected %b",
                             i, b, mv_at_valid, bus.mvmt_out, exp_mvmt());
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_make();
        test_break_ext();
        test_pair();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        n_checks++;
        if (n_wide !== 0) begin
            n_errors++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", n_wide);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_movement_decoder.md
Name: ps2_movement_decoder

Overview:
- Receives a PS/2 keyboard stream and converts make/break scancodes into the held-key movement vector that drives the renderer's mvmt_in port.
- Bit order of mvmt_out is {forward, backward, left, right}.
- Sits between the board PS/2 pins and the raycaster top. It runs entirely in the pixel clock domain.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered PS/2 clock or data changes value.
- TIMEOUT_CYCLES, 25000: clk_in cycles without a filtered PS/2 clock falling edge mid-frame before the partial frame is discarded (about 1 ms at the pixel clock).

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous reset, active-high
- ps2_clk_in  input  1  raw PS/2 clock, asynchronous, idle high
- ps2_data_in  input  1  raw PS/2 data, asynchronous, idle high
- mvmt_out  output  4  held keys {forward, backward, left, right}
- scancode_out  output  8  last valid received byte
- scancode_valid_out  output  1  one-cycle pulse; a new valid byte is on scancode_out
- frame_err_out  output  1  one-cycle pulse on a parity, start, stop or timeout error

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk_in, rst_in).
  - mvmt_out=0, scancode_out=0, both pulse outputs 0.
  - Held-key register=0, ext/brk flags=0, bit counter=0, timeout counter=0.
  - Synchronizer and filter state preset to 1 (idle).
  - Reset mid-frame abandons the frame with no error pulse.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer, then a filter.
  - The filtered value updates only after FILTER_LEN consecutive equal samples.
  - A falling edge is filtered clock going 1 to 0 between consecutive cycles.
  - Data is taken from filtered data in the cycle the edge is detected.
- Frame capture:
  - An 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
  - The bit counter runs 0..10 and advances on each falling edge; after bit 10 it returns to 0.
- Frame check, applied at bit 10:
  - Valid only if start==0, stop==1 and XOR(data, parity)==1.
  - Valid frame: the next cycle, scancode_out=data and scancode_valid_out=1 for exactly one cycle.
  - Invalid frame: frame_err_out=1 for one cycle, ext/brk cleared, mvmt_out unchanged.
- Timeout:
  - The counter clears on every falling edge and increments otherwise while the bit counter is nonzero.
  - On reaching TIMEOUT_CYCLES: bit counter=0, ext/brk cleared, frame_err_out pulses once.
  - With the bit counter at 0, the counter is held at 0.
- Decode, evaluated on the valid-byte cycle; mvmt_out updates on the same edge that raises scancode_valid_out:
  - 0xE0: ext=1.
  - 0xF0: brk=1.
  - 0x00 or 0xFF (keyboard overrun): all held bits=0, ext=brk=0.
  - Any other byte: if (ext, byte) is mapped, held[idx] = ~brk. Then ext=brk=0, whether mapped or not.
- Key map:
  - W 0x1D and E0 0x75 set forward.
  - S 0x1B and E0 0x72 set backward.
  - A 0x1C and E0 0x6B set left.
  - D 0x23 and E0 0x74 set right.
  - An extended byte matches only the E0 entries, and a plain byte only the plain entries.
- Output logic:
  - Eight held bits are kept: WASD and arrows separately.
  - mvmt_out[i] = OR of its WASD and arrow bits, so releasing one key of a pair keeps the direction held.
- Simultaneous events: a falling edge in the cycle the timeout fires is taken as bit 0 of a new frame; the timeout abort still applies.
- Opposing keys (forward+backward) are both reported; resolving them is the consumer's job.
- Typematic repeat makes are idempotent.

Test Plan:
- Send a valid frame for 0x1D with a 40 us bit period -> scancode_out=0x1D, scancode_valid_out high one cycle, mvmt_out=4'b1000.
- Hold state from the previous scenario; send F0, 1D -> two valid pulses, mvmt_out=4'b0000 on the second. Then send E0, 6B -> mvmt_out=4'b0010.
- Hold W and the up arrow (1D; E0 75), then release W (F0 1D) -> mvmt_out stays 4'b1000. Release the arrow (E0 F0 75) -> 4'b0000.
- Send 0x1C with the parity bit flipped -> frame_err_out one pulse, no valid pulse, mvmt_out unchanged. A following good 0x1C -> mvmt_out=4'b0010.
- Send 5 bits, then idle for TIMEOUT_CYCLES -> frame_err_out pulses once. A subsequent full 0x23 frame decodes -> mvmt_out=4'b0001.
- Inject 2-cycle glitches on ps2_clk_in with FILTER_LEN=4 -> no bit counted. Hold a key, then send 0xFF -> mvmt_out=0. Assert rst_in mid-frame -> all outputs 0, next frame decodes normally.
